// File: rtl/seq_detector_param.sv
// Serial pattern detector with loadable pattern, overlap control and saturating match count.
// Define SEQ_DET_CNT_EN to build the match counter; otherwise match_cnt is tied to zero.
module seq_detector_param #(
  parameter int                 PAT_W   = 3,
  parameter logic [PAT_W-1:0]   PAT_RST = PAT_W'(3'b101),
  parameter bit                 OUT_REG = 1'b0,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x_en,
  input  logic             x,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap_en,
  input  logic             clr_cnt,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int FW = $clog2(PAT_W);
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W - 1);

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [PAT_W-1:0] win;
  logic             full;
  logic             take;
  logic             hit;

  // Window is the candidate match: stored history plus the bit on the wire now.
  assign win  = {hist_q, x};
  assign full = (fill_q == FILL_MAX);
  assign take = x_en & ~pat_load;
  assign hit  = take & full & (win == pat_q);

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    if (pat_load) begin
      pat_d  = pat_in;
      fill_d = '0;
    end else if (x_en) begin
      hist_d = win[PAT_W-2:0];
      if (hit && !overlap_en) begin
        fill_d = '0;
      end else if (!full) begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q  <= PAT_RST;
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  generate
    if (OUT_REG) begin : g_yreg
      logic y_q;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          y_q <= 1'b0;
        end else begin
          y_q <= hit;
        end
      end
      assign y = y_q;
    end else begin : g_ymealy
      assign y = hit;
    end
  endgenerate

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over a same-cycle hit; count sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`else
  logic unused_clr;
  assign unused_clr = clr_cnt;
  assign match_cnt  = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: three configurations share one stimulus stream,
// checked each cycle against a queue-based model plus literal expectations.
module tb_seq_detector_param;

  typedef bit bq_t[$];

`ifdef SEQ_DET_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       x_en = 1'b0;
  logic       x = 1'b0;
  logic       pat_load = 1'b0;
  logic       overlap_en = 1'b1;
  logic       clr_cnt = 1'b0;
  logic [2:0] pat3 = 3'b101;
  logic [3:0] pat4 = 4'b1101;
  logic       y0, y1, y2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_W(3), .OUT_REG(1'b0), .CNT_W(8)) d0 (
    .clk(clk), .reset(reset), .x_en(x_en), .x(x), .pat_load(pat_load),
    .pat_in(pat3), .overlap_en(overlap_en), .clr_cnt(clr_cnt),
    .y(y0), .match_cnt(cnt0)
  );

  seq_detector_param #(.PAT_W(4), .OUT_REG(1'b1), .CNT_W(8)) d1 (
    .clk(clk), .reset(reset), .x_en(x_en), .x(x), .pat_load(pat_load),
    .pat_in(pat4), .overlap_en(overlap_en), .clr_cnt(clr_cnt),
    .y(y1), .match_cnt(cnt1)
  );

  seq_detector_param #(.PAT_W(3), .OUT_REG(1'b1), .CNT_W(2)) d2 (
    .clk(clk), .reset(reset), .x_en(x_en), .x(x), .pat_load(pat_load),
    .pat_in(pat3), .overlap_en(overlap_en), .clr_cnt(clr_cnt),
    .y(y2), .match_cnt(cnt2)
  );

  function automatic void chk(input string nm, input longint act,
                              input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Model: queue of accepted bits since the last restart.
  bq_t         q0, q1, q2;
  logic [31:0] p0 = 32'b101;
  logic [31:0] p1 = 32'b0101;
  logic [31:0] p2 = 32'b101;
  bit          r1 = 1'b0;
  bit          r2 = 1'b0;
  int          c0 = 0;
  int          c1 = 0;
  int          c2 = 0;

  function automatic bit mhit(input bq_t q, input int w, input logic [31:0] p);
    logic [31:0] v;
    if (!x_en || pat_load || q.size() < w - 1) return 1'b0;
    v = '0;
    for (int i = w - 1; i >= 1; i--) v = (v << 1) | 32'(q[q.size() - i]);
    v = (v << 1) | 32'(x);
    return v == p;
  endfunction

  function automatic bq_t mstep(input bq_t q, input bit h);
    bq_t n;
    n = q;
    if (pat_load) begin
      n.delete();
    end else if (x_en) begin
      if (h && !overlap_en) begin
        n.delete();
      end else begin
        n.push_back(x);
        if (n.size() > 32) void'(n.pop_front());
      end
    end
    return n;
  endfunction

  function automatic int mcnt(input int c, input bit h, input int maxv);
    if (!CNT_ON) return 0;
    if (clr_cnt) return 0;
    if (h && c < maxv) return c + 1;
    return c;
  endfunction

  always @(posedge clk) begin
    bit h0, h1, h2;
    if (!reset) begin
      q0.delete(); q1.delete(); q2.delete();
      p0 = 32'b101; p1 = 32'b0101; p2 = 32'b101;
      r1 = 1'b0; r2 = 1'b0;
      c0 = 0; c1 = 0; c2 = 0;
    end else begin
      h0 = mhit(q0, 3, p0);
      h1 = mhit(q1, 4, p1);
      h2 = mhit(q2, 3, p2);
      q0 = mstep(q0, h0);
      q1 = mstep(q1, h1);
      q2 = mstep(q2, h2);
      if (pat_load) begin
        p0 = 32'(pat3); p1 = 32'(pat4); p2 = 32'(pat3);
      end
      r1 = h1; r2 = h2;
      c0 = mcnt(c0, h0, 255);
      c1 = mcnt(c1, h1, 255);
      c2 = mcnt(c2, h2, 3);
    end
  end

  always @(negedge clk) begin
    bit e0;
    e0 = reset ? mhit(q0, 3, p0) : 1'b0;
    chk("y0", y0, e0);
    chk("y1", y1, reset ? r1 : 1'b0);
    chk("y2", y2, reset ? r2 : 1'b0);
    chk("cnt0", cnt0, reset ? c0 : 0);
    chk("cnt1", cnt1, reset ? c1 : 0);
    chk("cnt2", cnt2, reset ? c2 : 0);
  end

  logic [15:0] l0, l1, l2;
  int          li = 0;

  task automatic send(input logic en, input logic xb, input logic ld = 1'b0,
                      input logic clr = 1'b0, input logic rs = 1'b1);
    @(posedge clk);
    #1;
    x_en = en; x = xb; pat_load = ld; clr_cnt = clr; reset = rs;
    @(negedge clk);
    if (li < 16) begin
      l0[li] = y0; l1[li] = y1; l2[li] = y2;
    end
    li++;
  endtask

  task automatic restart();
    send(1'b0, 1'b0, 1'b1, 1'b1);
    li = 0; l0 = '0; l1 = '0; l2 = '0;
  endtask

  task automatic stream(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) send(1'b1, bits[n - 1 - i]);
    send(1'b1, 1'b0);
  endtask

  initial begin
    l0 = '0; l1 = '0; l2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_y0", y0, 0);
    chk("rst_y2", y2, 0);
    chk("rst_cnt0", cnt0, 0);
    send(1'b0, 1'b0);
    restart();

    overlap_en = 1'b1;
    stream(16'b1010100101, 10);
    chk("t1_y0_log", l0[9:0], 10'h214);
    chk("t1_y2_log", l2[10:0], 11'h428);
    chk("t1_y1_log", l1[10:0], 0);
    chk("t1_cnt0", cnt0, CNT_ON ? 3 : 0);

    restart();
    overlap_en = 1'b0;
    stream(16'b1010100101, 10);
    chk("t2_y0_log", l0[9:0], 10'h204);
    chk("t2_cnt0", cnt0, CNT_ON ? 2 : 0);

    restart();
    overlap_en = 1'b1;
    stream(16'b1101101, 7);
    chk("t3_y1_log", l1[7:0], 8'h90);
    restart();
    overlap_en = 1'b0;
    stream(16'b1101101, 7);
    chk("t3n_y1_log", l1[7:0], 8'h10);

    restart();
    overlap_en = 1'b1;
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    send(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    chk("t4_rst_y0_log", l0[7:0], 8'h40);
    chk("t4_rst_cnt0", cnt0, CNT_ON ? 1 : 0);

    restart();
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    send(1'b1, 1'b1, 1'b1);
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    chk("t4_load_y0_log", l0[7:0], 8'h40);

    restart();
    send(1'b1, 1'b1);
    send(1'b0, 1'b1);
    send(1'b0, 1'b0);
    send(1'b0, 1'b1);
    send(1'b1, 1'b0);
    send(1'b0, 1'b1);
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    chk("t5_gap_y0_log", l0[7:0], 8'h40);
    chk("t5_gap_y2_log", l2[7:0], 8'h80);

    restart();
    overlap_en = 1'b1;
    stream(16'b10101010101, 11);
    chk("t6_y0_log", l0[10:0], 11'h554);
    chk("t6_sat_cnt2", cnt2, CNT_ON ? 3 : 0);
    chk("t6_cnt0", cnt0, CNT_ON ? 5 : 0);
    send(1'b1, 1'b1, 1'b0, 1'b1);
    chk("t6_clr_hit_y0", l0[12], 1);
    send(1'b1, 1'b0);
    chk("t6_clr_cnt0", cnt0, 0);
    chk("t6_clr_cnt2", cnt2, 0);
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    chk("t6_post_cnt0", cnt0, CNT_ON ? 1 : 0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
